traffic_queue_model: RTL and testbench
======================================

Name: traffic_queue_model

Overview:
- Synthesizable vehicle-queue model for the opposite side of the Breadboard interface. It consumes `trafficLightOutput` and produces the packed lane-count bus plus `emgSignal`/`emgLane`.
- Per lane: adds arriving cars and drains cars at a fixed rate while that lane's light is green.
- Runs the emergency-vehicle request/clear handshake.
- Closes the loop for self-checking benches and FPGA demos, replacing hand-written lane stimulus.

Parameters:
- DEPART_DIV, 4, cycles between departures while a lane is green (>=1).
- EMG_CLEAR, 6, consecutive green cycles on the emergency lane before the request drops.
- EMG_TIMEOUT, 64, maximum cycles emgSignal stays high.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- arrive  in  8  per-lane arrival pulse, one car per set bit per cycle. Lane index i: 0=S1, 1=S2, 2=E1, 3=E2, 4=N1, 5=N2, 6=W1, 7=W2.
- trafficLightOutput  in  8  green per lane, same index as arrive.
- load_en  in  1  preset all counts from load_data.
- load_data  in  64  packed preset, same packing as lanes.
- emg_req  in  1  one-cycle emergency request pulse.
- emg_req_lane  in  3  lane index of the emergency vehicle.
- lanes  out  64  packed counts {W1,W2,S1,S2,E1,E2,N1,N2}. W1=[63:56], N2=[7:0].
- emgSignal  out  1  emergency active.
- emgLane  out  8  one-hot emergency lane, same index as arrive; zero when inactive.
- emg_done  out  1  one-cycle pulse when an emergency ends (clear or timeout).

Behaviour:
- Reset: all counts 0, all dividers 0, emgSignal=0, emgLane=0, emg_done=0, FSM=IDLE. Reset overrides load_en, emg_req and arrive in the same cycle.
- All outputs are registered. A count change is visible on lanes one cycle after the causing input edge.
- Per-lane counter (8-bit, unsigned):
  - Divider behaviour:
    - The divider increments while green and count>0.
    - When the divider reaches DEPART_DIV-1, the lane takes a depart tick and the divider returns to 0.
    - The divider clears to 0 whenever the light is not green or count=0.
  - next = count + arrive[i] - depart_tick, with the following boundaries:
    - arrive and depart in the same cycle: count unchanged.
    - Saturates at 255: an arrival at 255 without a depart is dropped.
    - Never goes below 0.
  - load_en has priority over arrive/depart. It sets counts and clears dividers.
- Emergency FSM:
  - IDLE:
    - On emg_req, latch the lane.
    - Next cycle: emgSignal=1, emgLane=1<<lane, go to ACTIVE.
    - Clear the green counter and the timeout counter.
  - ACTIVE:
    - The green counter increments while trafficLightOutput[lane]=1 and resets to 0 on any non-green cycle.
    - When the green counter reaches EMG_CLEAR, go to DONE.
    - Timeout counter:
      - Increments every ACTIVE cycle.
      - When it reaches EMG_TIMEOUT, go to DONE.
      - If both conditions hit in the same cycle, it is treated as a clear.
    - emg_req while ACTIVE is ignored (no queueing).
  - DONE (1 cycle): emgSignal=0, emgLane=0, emg_done=1. Return to IDLE. emg_req in this cycle is ignored.
  - The emergency vehicle is not counted in lanes.
  - load_en does not affect the FSM.
- Reset mid-emergency: next cycle is IDLE with all outputs at reset values; no emg_done pulse.
- DEPART_DIV=1: one departure per green cycle.

Decomposition:
- Package traffic_pkg:
  - lane index constants LANE_S1..LANE_W2.
  - LANE_W=8, NUM_LANES=8.
  - pack/unpack function between index order and lanes bus order.
  - FSM state enum {IDLE, ACTIVE, DONE}.
- Sub-module lane_queue (parameter DEPART_DIV): one counter plus divider, 8 instances via generate.
- Top holds the emergency FSM and the packing logic.

Test Plan:
- Reset, then 3 arrive pulses on S1 (bit0) with lights off → lanes[47:40]=3 after last pulse+1; other bytes 0.
- Preload W1=10 via load_en, hold trafficLightOutput[6]=1 for 20 cycles at DEPART_DIV=4 → W1=5. Dividers cleared on light off: W1 remains 5 after 20 more red cycles.
- N2 at 255 plus arrive[5] pulses → stays 255. N2=0 green with arrive[5] each cycle and DEPART_DIV=1 → goes 0→1 then holds 1 (arrive+depart cancel).
- emg_req lane 3 (E2) → emgSignal=1, emgLane=8'b00001000 next cycle. Green 3 cycles, one red cycle, then 6 green cycles → emg_done pulses after the 6th; emgSignal=0.
- emg_req lane 0 with light never green → emgSignal drops after exactly 64 ACTIVE cycles with emg_done=1. A second emg_req during ACTIVE has no effect.
- rst asserted mid-ACTIVE together with load_en and arrive=8'hFF → all outputs 0 next cycle; no emg_done.

Source files
------------

// File: rtl/traffic_queue_model_pkg.sv
// Shared lane indices, count types, emergency FSM states and the helpers that map
// lanes between index order (S1..W2) and the packed lanes-bus byte order.
package traffic_pkg;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 8;
  localparam int BUS_W     = LANE_W * NUM_LANES;

  localparam int LANE_S1 = 0;
  localparam int LANE_S2 = 1;
  localparam int LANE_E1 = 2;
  localparam int LANE_E2 = 3;
  localparam int LANE_N1 = 4;
  localparam int LANE_N2 = 5;
  localparam int LANE_W1 = 6;
  localparam int LANE_W2 = 7;

  typedef logic [LANE_W-1:0] count_t;
  typedef count_t [NUM_LANES-1:0] lane_arr_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } emg_state_e;

  // Byte slot on the bus for a lane index; the bus reads {W1,W2,S1,S2,E1,E2,N1,N2}.
  function automatic int lane_slot(input int idx);
    case (idx)
      LANE_S1: return 5;
      LANE_S2: return 4;
      LANE_E1: return 3;
      LANE_E2: return 2;
      LANE_N1: return 1;
      LANE_N2: return 0;
      LANE_W1: return 7;
      LANE_W2: return 6;
      default: return 0;
    endcase
  endfunction

  function automatic logic [BUS_W-1:0] pack_lanes(input lane_arr_t counts);
    logic [BUS_W-1:0] bus;
    bus = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      bus[lane_slot(i)*LANE_W +: LANE_W] = counts[i];
    end
    return bus;
  endfunction

  function automatic lane_arr_t unpack_lanes(input logic [BUS_W-1:0] bus);
    lane_arr_t counts;
    for (int i = 0; i < NUM_LANES; i++) begin
      counts[i] = bus[lane_slot(i)*LANE_W +: LANE_W];
    end
    return counts;
  endfunction

endpackage

// File: rtl/traffic_queue_model_if.sv
// Lane-traffic and emergency handshake bundle between the light controller side
// (master) and the vehicle-queue model (slave).
interface traffic_queue_model_if;
  logic [7:0]  arrive;
  logic [7:0]  trafficLightOutput;
  logic        load_en;
  logic [63:0] load_data;
  logic        emg_req;
  logic [2:0]  emg_req_lane;
  logic [63:0] lanes;
  logic        emgSignal;
  logic [7:0]  emgLane;
  logic        emg_done;

  modport master (
    output arrive, trafficLightOutput, load_en, load_data, emg_req, emg_req_lane,
    input  lanes, emgSignal, emgLane, emg_done
  );

  modport slave (
    input  arrive, trafficLightOutput, load_en, load_data, emg_req, emg_req_lane,
    output lanes, emgSignal, emgLane, emg_done
  );
endinterface

// File: rtl/traffic_queue_model_lane_queue.sv
// One lane's car counter: saturating arrivals, departures every DEPART_DIV green
// cycles while cars are waiting, and a preset that overrides both.
module lane_queue
  import traffic_pkg::*;
#(
  parameter int DEPART_DIV = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_arrive,
  input  logic   i_green,
  input  logic   i_load_en,
  input  count_t i_load_data,
  output count_t o_count
);

  localparam int DIV_W = (DEPART_DIV > 1) ? $clog2(DEPART_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DEPART_DIV - 1);

  count_t           r_count;
  logic [DIV_W-1:0] r_div;
  count_t           w_count_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic             w_draining;
  logic             w_depart;

  assign w_draining = i_green && (r_count != '0);
  assign w_depart   = w_draining && (r_div == DIV_LAST);

  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    w_count_nxt = r_count;
    w_div_nxt   = '0;
    if (i_arrive && !w_depart) begin
      if (r_count != '1) w_count_nxt = r_count + 1'b1;
    end else if (!i_arrive && w_depart) begin
      w_count_nxt = r_count - 1'b1;
    end
    if (w_draining && !w_depart) w_div_nxt = r_div + 1'b1;
  end

  // NOTE: state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_div   <= '0;
    end else if (i_load_en) begin
      r_count <= i_load_data;
      r_div   <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_div   <= w_div_nxt;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/traffic_queue_model.sv
// Vehicle-queue model: eight lane counters packed onto the lanes bus plus the
// emergency request / clear / timeout handshake.
module traffic_queue_model
  import traffic_pkg::*;
#(
  parameter int DEPART_DIV  = 4,
  parameter int EMG_CLEAR   = 6,
  parameter int EMG_TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 rst,
  traffic_queue_model_if.slave bus
);

  localparam int GREEN_W = $clog2(EMG_CLEAR + 1);
  localparam int TO_W    = $clog2(EMG_TIMEOUT + 1);

  lane_arr_t w_counts;
  lane_arr_t w_load;

  assign w_load = unpack_lanes(bus.load_data);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_queue #(.DEPART_DIV(DEPART_DIV)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .i_arrive   (bus.arrive[g]),
      .i_green    (bus.trafficLightOutput[g]),
      .i_load_en  (bus.load_en),
      .i_load_data(w_load[g]),
      .o_count    (w_counts[g])
    );
  end

  assign bus.lanes = pack_lanes(w_counts);

  emg_state_e         r_state, w_state_nxt;
  logic [2:0]         r_lane, w_lane_nxt;
  logic [GREEN_W-1:0] r_green, w_green_nxt;
  logic [TO_W-1:0]    r_to, w_to_nxt;
  logic               r_emg_signal, w_emg_signal_nxt;
  logic [7:0]         r_emg_lane, w_emg_lane_nxt;
  logic               r_emg_done, w_emg_done_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_lane       <= '0;
      r_green      <= '0;
      r_to         <= '0;
      r_emg_signal <= 1'b0;
      r_emg_lane   <= '0;
      r_emg_done   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lane       <= w_lane_nxt;
      r_green      <= w_green_nxt;
      r_to         <= w_to_nxt;
      r_emg_signal <= w_emg_signal_nxt;
      r_emg_lane   <= w_emg_lane_nxt;
      r_emg_done   <= w_emg_done_nxt;
    end
  end

  // Clear wins a tie with timeout simply because both lead to the same DONE cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_lane_nxt  = r_lane;
    w_green_nxt = r_green;
    w_to_nxt    = r_to;
    case (r_state)
      IDLE: begin
        if (bus.emg_req) begin
          w_state_nxt = ACTIVE;
          w_lane_nxt  = bus.emg_req_lane;
          w_green_nxt = '0;
          w_to_nxt    = '0;
        end
      end
      ACTIVE: begin
        w_green_nxt = bus.trafficLightOutput[r_lane] ? r_green + 1'b1 : '0;
        w_to_nxt    = r_to + 1'b1;
        if (w_green_nxt == GREEN_W'(EMG_CLEAR) || w_to_nxt == TO_W'(EMG_TIMEOUT)) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in flops with it.
  always_comb begin
    w_emg_signal_nxt = (w_state_nxt == ACTIVE);
    w_emg_lane_nxt   = (w_state_nxt == ACTIVE) ? (8'b1 << w_lane_nxt) : 8'b0;
    w_emg_done_nxt   = (w_state_nxt == DONE);
  end

  assign bus.emgSignal = r_emg_signal;
  assign bus.emgLane   = r_emg_lane;
  assign bus.emg_done  = r_emg_done;

endmodule

// File: tb/tb_traffic_queue_model.sv
// Scoreboard bench: two instances (DEPART_DIV 4 and 1) share stimulus; a queue-based
// reference model predicts every registered output cycle by cycle.
module tb_traffic_queue_model;

  localparam int EMG_CLEAR   = 6;
  localparam int EMG_TIMEOUT = 64;
  localparam int SLOT [8]    = '{5, 4, 3, 2, 1, 0, 7, 6};
  localparam int DIVS [2]    = '{4, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  arrive;
  logic [7:0]  lights;
  logic        load_en;
  logic [63:0] load_data;
  logic        emg_req;
  logic [2:0]  emg_lane_in;

  int errors = 0;
  int checks = 0;

  traffic_queue_model_if if4 ();
  traffic_queue_model_if if1 ();

  assign if4.arrive = arrive;      assign if1.arrive = arrive;
  assign if4.trafficLightOutput = lights; assign if1.trafficLightOutput = lights;
  assign if4.load_en = load_en;    assign if1.load_en = load_en;
  assign if4.load_data = load_data; assign if1.load_data = load_data;
  assign if4.emg_req = emg_req;    assign if1.emg_req = emg_req;
  assign if4.emg_req_lane = emg_lane_in; assign if1.emg_req_lane = emg_lane_in;

  traffic_queue_model #(.DEPART_DIV(4), .EMG_CLEAR(EMG_CLEAR), .EMG_TIMEOUT(EMG_TIMEOUT)) dut4 (
    .clk(clk), .rst(rst), .bus(if4.slave)
  );
  traffic_queue_model #(.DEPART_DIV(1), .EMG_CLEAR(EMG_CLEAR), .EMG_TIMEOUT(EMG_TIMEOUT)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] lanes4;
    logic [63:0] lanes1;
    logic        sig;
    logic [7:0]  lane_oh;
    logic        done;
  } exp_t;

  exp_t sb [$];

  // Reference state: per-lane car count and consecutive productive green cycles.
  int m_cnt    [2][8];
  int m_streak [2][8];
  bit m_active, m_done;
  int m_lane, m_green, m_elapsed;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_bus(input int d);
    logic [63:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) b[8*SLOT[i] +: 8] = 8'(m_cnt[d][i]);
    return b;
  endfunction

  task automatic model_step();
    exp_t e;
    if (rst) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 8; i++) begin
          m_cnt[d][i] = 0;
          m_streak[d][i] = 0;
        end
      m_active = 0; m_done = 0; m_lane = 0; m_green = 0; m_elapsed = 0;
    end else begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 8; i++) begin
          if (load_en) begin
            m_cnt[d][i] = int'(load_data[8*SLOT[i] +: 8]);
            m_streak[d][i] = 0;
          end else begin
            int dep;
            dep = 0;
            if (lights[i] && m_cnt[d][i] > 0) begin
              m_streak[d][i]++;
              if (m_streak[d][i] == DIVS[d]) begin
                dep = 1;
                m_streak[d][i] = 0;
              end
            end else begin
              m_streak[d][i] = 0;
            end
            m_cnt[d][i] = m_cnt[d][i] + int'(arrive[i]) - dep;
            if (m_cnt[d][i] > 255) m_cnt[d][i] = 255;
          end
        end
      if (m_done) begin
        m_done = 0;
      end else if (m_active) begin
        m_elapsed++;
        m_green = lights[m_lane] ? m_green + 1 : 0;
        if (m_green == EMG_CLEAR || m_elapsed == EMG_TIMEOUT) begin
          m_active = 0;
          m_done = 1;
        end
      end else if (emg_req) begin
        m_active = 1;
        m_lane = int'(emg_lane_in);
        m_green = 0;
        m_elapsed = 0;
      end
    end
    e.lanes4  = model_bus(0);
    e.lanes1  = model_bus(1);
    e.sig     = m_active;
    e.lane_oh = m_active ? (8'h01 << m_lane) : 8'h00;
    e.done    = m_done;
    sb.push_back(e);
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic tick();
    model_step();
    @(negedge clk);
    emg_req = 1'b0;
    load_en = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("lanes_div4", if4.lanes, e.lanes4);
        check("lanes_div1", if1.lanes, e.lanes1);
        check("emg_div4", {if4.emgSignal, if4.emgLane, if4.emg_done},
              {e.sig, e.lane_oh, e.done});
        check("emg_div1", {if1.emgSignal, if1.emgLane, if1.emg_done},
              {e.sig, e.lane_oh, e.done});
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1; arrive = '0; lights = '0; load_en = 1'b0; load_data = '0;
    emg_req = 1'b0; emg_lane_in = '0;
    @(negedge clk);
    tick(); tick();
    check("reset_lanes", if4.lanes, 64'h0);
    check("reset_emg", {if4.emgSignal, if4.emgLane, if4.emg_done}, 10'h0);
    rst = 1'b0;

    // Three S1 arrivals with lights off.
    arrive = 8'h01;
    repeat (3) tick();
    check("s1_three", if4.lanes, 64'h0000_0300_0000_0000);
    arrive = 8'h00;
    tick();
    check("s1_hold", if4.lanes, 64'h0000_0300_0000_0000);

    // W1 preset to 10, drained for 20 green cycles.
    load_en = 1'b1; load_data = 64'h0A00_0000_0000_0000;
    tick();
    check("w1_load", if4.lanes, 64'h0A00_0000_0000_0000);
    lights = 8'h40;
    repeat (20) tick();
    check("w1_drain", if4.lanes[63:56], 64'd5);
    check("w1_drain_div1", if1.lanes[63:56], 64'd0);
    lights = 8'h00;
    repeat (20) tick();
    check("w1_red_hold", if4.lanes[63:56], 64'd5);
    lights = 8'h40; repeat (2) tick();
    lights = 8'h00; tick();
    lights = 8'h40; repeat (2) tick();
    lights = 8'h00;
    check("w1_div_cleared", if4.lanes[63:56], 64'd5);

    // N2 saturation, then arrive/depart cancellation at DEPART_DIV=1.
    load_en = 1'b1; load_data = 64'h0000_0000_0000_00FF;
    tick();
    arrive = 8'h20;
    repeat (3) tick();
    check("n2_sat", if4.lanes[7:0], 64'd255);
    load_en = 1'b1; load_data = '0;
    tick();
    lights = 8'h20;
    tick();
    check("n2_first", if1.lanes[7:0], 64'd1);
    repeat (5) tick();
    check("n2_cancel", if1.lanes[7:0], 64'd1);
    arrive = '0; lights = '0;

    // Randomized traffic, presets and emergency requests.
    for (int n = 0; n < 400; n++) begin
      arrive      = 8'($urandom & $urandom);
      lights      = 8'($urandom);
      load_en     = ($urandom_range(0, 49) == 0);
      load_data   = {$urandom, $urandom};
      emg_req     = ($urandom_range(0, 19) == 0);
      emg_lane_in = 3'($urandom_range(0, 7));
      tick();
    end
    arrive = '0; lights = '0;
    rst = 1'b1; tick(); rst = 1'b0;

    // Emergency on E2 cleared by green, with one red interrupting.
    emg_req = 1'b1; emg_lane_in = 3'd3;
    tick();
    check("e2_active", {if4.emgSignal, if4.emgLane}, {1'b1, 8'b0000_1000});
    lights = 8'h08; repeat (3) tick();
    lights = 8'h00; tick();
    lights = 8'h08; repeat (5) tick();
    check("e2_not_yet", {if4.emgSignal, if4.emg_done}, 2'b10);
    tick();
    check("e2_done", {if4.emgSignal, if4.emgLane, if4.emg_done}, {1'b0, 8'h00, 1'b1});
    lights = 8'h00;
    tick();
    check("e2_done_pulse", if4.emg_done, 64'd0);

    // Emergency on S1 never green: timeout after 64 active cycles.
    emg_req = 1'b1; emg_lane_in = 3'd0;
    tick();
    for (int k = 1; k < EMG_TIMEOUT; k++) begin
      if (k == 10) begin
        emg_req = 1'b1; emg_lane_in = 3'd5;
      end
      tick();
    end
    check("s1_before_to", {if4.emgSignal, if4.emgLane}, {1'b1, 8'h01});
    tick();
    check("s1_timeout", {if4.emgSignal, if4.emgLane, if4.emg_done}, {1'b0, 8'h00, 1'b1});
    emg_req = 1'b1; emg_lane_in = 3'd2;
    tick();
    check("req_in_done", {if4.emgSignal, if4.emg_done}, 2'b00);

    // Reset mid-emergency overriding preset and arrivals.
    emg_req = 1'b1; emg_lane_in = 3'd2;
    tick(); tick();
    rst = 1'b1; load_en = 1'b1; load_data = '1; arrive = 8'hFF;
    tick();
    check("rst_mid_lanes", if4.lanes, 64'h0);
    check("rst_mid_emg", {if4.emgSignal, if4.emgLane, if4.emg_done}, 10'h0);
    rst = 1'b0; arrive = '0;
    tick();
    check("after_rst_done", if4.emg_done, 64'd0);

    @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
